sync_conditioner: RTL and testbench

//  Front-end stage ahead of the csync generator. Takes the raw Atari hsync/vsync

---
 rtl/sync_conditioner.sv | 189 ++++++++++++++++++
 tb/tb_sync_conditioner.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/sync_conditioner.sv
// sync_conditioner: resynchronises and deglitches the raw hsync/vsync pins,
// emits hfall/vrise strobes, measures the hsync line period and tracks line lock.
// Optional build macro VSYNC_QUAL_EN: when defined, vrise only fires while locked.
module sync_conditioner #(
    parameter int FILT_LEN   = 4,
    parameter int PER_W      = 10,
    parameter int NOM_PERIOD = 766,
    parameter int TOL        = 8,
    parameter int LOCK_LINES = 4,
    parameter int LOSS_LINES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             hsync_in,
    input  logic             vsync_in,
    output logic             hsync,
    output logic             vsync,
    output logic             hfall,
    output logic             vrise,
    output logic [PER_W-1:0] line_period,
    output logic             locked
);

    localparam int CNT_W  = (FILT_LEN < 2) ? 1 : $clog2(FILT_LEN + 1);
    localparam int GOOD_W = (LOCK_LINES < 2) ? 1 : $clog2(LOCK_LINES + 1);
    localparam int MISS_W = (LOSS_LINES < 2) ? 1 : $clog2(LOSS_LINES + 1);

    localparam logic [PER_W-1:0] PER_LO  = PER_W'(NOM_PERIOD - TOL);
    localparam logic [PER_W-1:0] PER_HI  = PER_W'(NOM_PERIOD + TOL);
    localparam logic [PER_W-1:0] PER_TMO = PER_W'(NOM_PERIOD + TOL + 1);

    typedef enum logic [1:0] {SEARCH = 2'd0, MEASURE = 2'd1, LOCKED = 2'd2} state_t;

    // Channel 0 is hsync, channel 1 is vsync.
    logic [1:0]       raw;
    logic [1:0]       meta_reg;
    logic [1:0]       sync_reg;
    logic [1:0]       filt_reg;
    logic [1:0]       flip;
    logic [CNT_W-1:0] cnt_reg [2];

    logic             hfall_reg;
    logic             vrise_reg;
    logic [PER_W-1:0] pcnt_reg;
    logic [PER_W-1:0] line_period_reg;

    state_t           state_reg, state_next;
    logic [GOOD_W-1:0] good_reg, good_next;
    logic [MISS_W-1:0] miss_reg, miss_next;

    logic good_hfall;
    logic short_hfall;
    logic timeout;

    assign raw = {vsync_in, hsync_in};

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_chan
            // A level change is accepted on the FILT_LEN-th consecutive disagreeing sample.
            assign flip[gi] = (sync_reg[gi] != filt_reg[gi]) &&
                              (cnt_reg[gi] == CNT_W'(FILT_LEN - 1));

            // Two-flop synchroniser followed by the run-length glitch filter.
            always_ff @(posedge clk) begin
                if (rst) begin
                    meta_reg[gi] <= 1'b1;
                    sync_reg[gi] <= 1'b1;
                    filt_reg[gi] <= 1'b1;
                    cnt_reg[gi]  <= '0;
                end else begin
                    meta_reg[gi] <= raw[gi];
                    sync_reg[gi] <= meta_reg[gi];
                    if (sync_reg[gi] == filt_reg[gi]) begin
                        cnt_reg[gi] <= '0;
                    end else if (flip[gi]) begin
                        filt_reg[gi] <= sync_reg[gi];
                        cnt_reg[gi]  <= '0;
                    end else begin
                        cnt_reg[gi] <= cnt_reg[gi] + 1'b1;
                    end
                end
            end
        end
    endgenerate

    // Edge strobes, registered so they line up with the filtered level change.
    always_ff @(posedge clk) begin
        if (rst) begin
            hfall_reg <= 1'b0;
            vrise_reg <= 1'b0;
        end else begin
            hfall_reg <= flip[0] & filt_reg[0];
`ifdef VSYNC_QUAL_EN
            vrise_reg <= flip[1] & ~filt_reg[1] & locked;
`else
            vrise_reg <= flip[1] & ~filt_reg[1];
`endif
        end
    end

    // Line period counter: restarts at 1 on each hfall and saturates instead of wrapping.
    always_ff @(posedge clk) begin
        if (rst) begin
            pcnt_reg        <= '0;
            line_period_reg <= '0;
        end else if (hfall_reg) begin
            pcnt_reg        <= PER_W'(1);
            line_period_reg <= pcnt_reg;
        end else if (pcnt_reg != '1) begin
            pcnt_reg <= pcnt_reg + 1'b1;
        end
    end

    assign good_hfall  = hfall_reg && (pcnt_reg >= PER_LO) && (pcnt_reg <= PER_HI);
    assign short_hfall = hfall_reg && (pcnt_reg < PER_LO);
    assign timeout     = !hfall_reg && (pcnt_reg == PER_TMO);

    // Lock FSM state and its good/miss line counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= SEARCH;
            good_reg  <= '0;
            miss_reg  <= '0;
        end else begin
            state_reg <= state_next;
            good_reg  <= good_next;
            miss_reg  <= miss_next;
        end
    end

    // Next-state logic: count good lines to lock, count short lines or a timeout to unlock.
    always_comb begin
        state_next = state_reg;
        good_next  = good_reg;
        miss_next  = miss_reg;
        unique case (state_reg)
            SEARCH: begin
                if (hfall_reg) begin
                    state_next = MEASURE;
                    good_next  = '0;
                end
            end
            MEASURE: begin
                if (good_hfall) begin
                    if (good_reg == GOOD_W'(LOCK_LINES - 1)) begin
                        state_next = LOCKED;
                        good_next  = '0;
                        miss_next  = '0;
                    end else begin
                        good_next = good_reg + 1'b1;
                    end
                end else if (hfall_reg) begin
                    good_next = '0;
                end else if (timeout) begin
                    state_next = SEARCH;
                end
            end
            LOCKED: begin
                if (timeout) begin
                    state_next = SEARCH;
                    miss_next  = '0;
                end else if (good_hfall) begin
                    miss_next = '0;
                end else if (short_hfall) begin
                    if (miss_reg == MISS_W'(LOSS_LINES - 1)) begin
                        state_next = SEARCH;
                        miss_next  = '0;
                    end else begin
                        miss_next = miss_reg + 1'b1;
                    end
                end
            end
            default: state_next = SEARCH;
        endcase
    end

    // Output logic: lock flag follows the registered state.
    always_comb begin
        locked = (state_reg == LOCKED);
    end

    assign hsync       = filt_reg[0];
    assign vsync       = filt_reg[1];
    assign hfall       = hfall_reg;
    assign vrise       = vrise_reg;
    assign line_period = line_period_reg;

endmodule

// File: tb/tb_sync_conditioner.sv
// Directed bench for sync_conditioner: reset, glitch filter, lock/tolerance/loss
// line sequences from a vector table, timeout and saturation, vsync strobe gating.
module tb_sync_conditioner;

    logic       clk = 1'b0;
    logic       rst;
    logic       hsync_in;
    logic       vsync_in;
    logic       hsync;
    logic       vsync;
    logic       hfall;
    logic       vrise;
    logic [9:0] line_period;
    logic       locked;

    int checks = 0;
    int errors = 0;

`ifdef VSYNC_QUAL_EN
    localparam int VR_UNLOCKED = 0;
`else
    localparam int VR_UNLOCKED = 1;
`endif

    typedef struct {
        int period;      // clocks from this line's pin fall to the next one
        bit vpulse;      // drive a vsync pulse during the line
        int exp_vrise;   // vrise strobes expected during the line
        int exp_lk_at;   // locked in the hfall cycle
        int exp_lk_aft;  // locked one cycle after hfall
        int exp_lp;      // line_period one cycle after hfall
    } vec_t;

    vec_t tbl [16];

    sync_conditioner dut (
        .clk        (clk),
        .rst        (rst),
        .hsync_in   (hsync_in),
        .vsync_in   (vsync_in),
        .hsync      (hsync),
        .vsync      (vsync),
        .hfall      (hfall),
        .vrise      (vrise),
        .line_period(line_period),
        .locked     (locked)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    // One line: hsync_in low for 16 clocks, then high; optional vsync pulse.
    task automatic run_line(input int period, input bit vpulse,
                            output int nfall, output int nvrise,
                            output int lk_at, output int lk_aft, output int lp);
        int fall_at;
        fall_at = -1;
        nfall   = 0;
        nvrise  = 0;
        lk_at   = -1;
        lk_aft  = -1;
        lp      = -1;
        for (int c = 0; c < period; c++) begin
            hsync_in = (c < 16) ? 1'b0 : 1'b1;
            vsync_in = (vpulse && c >= 100 && c < 120) ? 1'b0 : 1'b1;
            step();
            if (hfall) begin
                nfall++;
                fall_at = c;
                lk_at   = int'(locked);
            end
            if (vrise) nvrise++;
            if (fall_at >= 0 && c == fall_at + 1) begin
                lk_aft = int'(locked);
                lp     = int'(line_period);
            end
        end
    endtask

    initial begin
        int nfall, nvrise, lk_at, lk_aft, lp, stray;

        //           period vp  vrise        at aft lp
        tbl[0]  = '{766, 1'b0, 0,           0, 0, 1023};
        tbl[1]  = '{766, 1'b1, VR_UNLOCKED, 0, 0, 766};
        tbl[2]  = '{766, 1'b0, 0,           0, 0, 766};
        tbl[3]  = '{766, 1'b0, 0,           0, 0, 766};
        tbl[4]  = '{774, 1'b0, 0,           0, 1, 766};
        tbl[5]  = '{758, 1'b0, 0,           1, 1, 774};
        tbl[6]  = '{700, 1'b1, 1,           1, 1, 758};
        tbl[7]  = '{766, 1'b0, 0,           1, 1, 700};
        tbl[8]  = '{700, 1'b0, 0,           1, 1, 766};
        tbl[9]  = '{700, 1'b0, 0,           1, 1, 700};
        tbl[10] = '{766, 1'b0, 0,           1, 0, 700};
        tbl[11] = '{766, 1'b0, 0,           0, 0, 766};
        tbl[12] = '{766, 1'b0, 0,           0, 0, 766};
        tbl[13] = '{766, 1'b0, 0,           0, 0, 766};
        tbl[14] = '{766, 1'b0, 0,           0, 0, 766};
        tbl[15] = '{766, 1'b0, 0,           0, 1, 766};

        // Reset with pins low.
        rst      = 1'b1;
        hsync_in = 1'b0;
        vsync_in = 1'b0;
        step();
        step();
        chk("rst_hsync", int'(hsync), 1);
        chk("rst_vsync", int'(vsync), 1);
        chk("rst_hfall", int'(hfall), 0);
        chk("rst_vrise", int'(vrise), 0);
        chk("rst_locked", int'(locked), 0);
        chk("rst_line_period", int'(line_period), 0);
        $display("reset: hsync=%0d vsync=%0d locked=%0d line_period=%0d",
                 hsync, vsync, locked, line_period);
        hsync_in = 1'b1;
        vsync_in = 1'b1;
        repeat (3) step();
        rst = 1'b0;
        repeat (4) step();

        // Three-clock glitch must be rejected.
        stray    = 0;
        hsync_in = 1'b0;
        repeat (3) step();
        hsync_in = 1'b1;
        for (int i = 0; i < 12; i++) begin
            step();
            if (hfall || !hsync) stray++;
        end
        chk("glitch3_rejected", stray, 0);
        $display("glitch 3 clk: disturbances=%0d", stray);

        // Four-clock pulse is accepted with hfall on edge 6.
        hsync_in = 1'b0;
        for (int e = 1; e <= 8; e++) begin
            if (e == 5) hsync_in = 1'b1;
            step();
            chk($sformatf("pulse4_hfall_e%0d", e), int'(hfall), (e == 6) ? 1 : 0);
            if (e == 6) chk("pulse4_hsync_e6", int'(hsync), 0);
        end
        $display("pulse 4 clk: hfall checked on edges 1..8");
        // Let the period counter saturate and the FSM time out back to SEARCH.
        repeat (1100) step();

        // Table-driven line sequences: lock, tolerance, loss by short lines, relock.
        for (int r = 0; r < 16; r++) begin
            run_line(tbl[r].period, tbl[r].vpulse, nfall, nvrise, lk_at, lk_aft, lp);
            chk($sformatf("row%0d_nfall", r), nfall, 1);
            chk($sformatf("row%0d_vrise", r), nvrise, tbl[r].exp_vrise);
            chk($sformatf("row%0d_lock_at", r), lk_at, tbl[r].exp_lk_at);
            chk($sformatf("row%0d_lock_after", r), lk_aft, tbl[r].exp_lk_aft);
            chk($sformatf("row%0d_line_period", r), lp, tbl[r].exp_lp);
            $display("row %0d: period=%0d hfalls=%0d vrise=%0d locked %0d->%0d line_period=%0d",
                     r, tbl[r].period, nfall, nvrise, lk_at, lk_aft, lp);
        end

        // Hold hsync high after lock: timeout at pcnt 775, line_period kept.
        hsync_in = 1'b1;
        vsync_in = 1'b1;
        stray    = 0;
        for (int k = 761; k <= 1100; k++) begin
            step();
            if (hfall) stray++;
            if (k == 774) chk("hold_locked_774", int'(locked), 1);
            if (k == 776) begin
                chk("hold_locked_776", int'(locked), 0);
                chk("hold_line_period", int'(line_period), 766);
            end
        end
        chk("hold_no_hfall", stray, 0);
        $display("hold high: locked=%0d line_period=%0d", locked, line_period);

        // Next hfall after the long gap reports the saturated count.
        run_line(766, 1'b0, nfall, nvrise, lk_at, lk_aft, lp);
        chk("sat_nfall", nfall, 1);
        chk("sat_line_period", lp, 1023);
        chk("sat_lock_after", lk_aft, 0);
        $display("after gap: line_period=%0d locked=%0d", lp, lk_aft);

        // Reset mid-line returns everything to reset values.
        hsync_in = 1'b0;
        repeat (3) step();
        rst = 1'b1;
        step();
        chk("midrst_hsync", int'(hsync), 1);
        chk("midrst_hfall", int'(hfall), 0);
        chk("midrst_locked", int'(locked), 0);
        chk("midrst_line_period", int'(line_period), 0);
        $display("mid-line reset: hsync=%0d line_period=%0d", hsync, line_period);
        rst      = 1'b0;
        hsync_in = 1'b1;
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
